// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with one holding register per channel.
// Optional sticky out-of-range select flag (sel_err) is built when DEMUX_SEL_ERR_EN is defined.
module demux_1ton_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data
`ifdef DEMUX_SEL_ERR_EN
  ,
  output logic               sel_err
`endif
);

  logic [N-1:0]            full_q, full_d, load;
  logic [N-1:0][WIDTH-1:0] data_q, data_d;

  // Out-of-range selects match no channel, so in_ready falls back to 1 and nothing loads.
  always_comb begin
    in_ready = 1'b1;
    load     = '0;
    for (int i = 0; i < N; i++) begin
      if (in_sel == SEL_W'(i)) begin
        in_ready = !full_q[i] || out_ready[i];
        load[i]  = in_valid && (!full_q[i] || out_ready[i]);
      end
    end
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int i = 0; i < N; i++) begin
      full_d[i] = load[i] || (full_q[i] && !out_ready[i]);
      if (load[i]) begin
        data_d[i] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;

`ifdef DEMUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d, in_range;

  always_comb begin
    in_range = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_sel == SEL_W'(i)) begin
        in_range = 1'b1;
      end
    end
    sel_err_d = sel_err_q || (in_valid && !in_range);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule
